// File: rtl/dm_bank_scheduler.sv
// Write-port scheduler for the 4-bank data memory: splits a 4-lane vector store into
// bank-conflict-free issue cycles and gives a scalar store priority while idle.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 10
`endif

module dm_bank_scheduler #(
    parameter int ADDR_W = `DATAMEM_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vreq_valid,
    output logic              vreq_ready,
    input  logic [3:0]        vreq_mask,
    input  logic [ADDR_W-1:0] vreq_addr0,
    input  logic [ADDR_W-1:0] vreq_addr1,
    input  logic [ADDR_W-1:0] vreq_addr2,
    input  logic [ADDR_W-1:0] vreq_addr3,
    input  logic [31:0]       vreq_data0,
    input  logic [31:0]       vreq_data1,
    input  logic [31:0]       vreq_data2,
    input  logic [31:0]       vreq_data3,
    output logic              vreq_done,
    input  logic              sreq_valid,
    input  logic [ADDR_W-1:0] sreq_addr,
    input  logic [31:0]       sreq_data,
    input  logic [3:0]        sreq_be,
    output logic              sreq_stall,
    output logic [ADDR_W-3:0] bank_addr0,
    output logic [ADDR_W-3:0] bank_addr1,
    output logic [ADDR_W-3:0] bank_addr2,
    output logic [ADDR_W-3:0] bank_addr3,
    output logic [31:0]       bank_data0,
    output logic [31:0]       bank_data1,
    output logic [31:0]       bank_data2,
    output logic [31:0]       bank_data3,
    output logic [3:0]        bank_we0,
    output logic [3:0]        bank_we1,
    output logic [3:0]        bank_we2,
    output logic [3:0]        bank_we3,
    output logic              busy
);

    localparam int ROW_W = ADDR_W - 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        pending;
    logic [3:0]        pending_nxt;
    logic              accept_vec;
    logic              accept_sca;

    logic [ADDR_W-1:0] vaddr [4];
    logic [31:0]       vdata [4];
    logic [ADDR_W-1:0] lane_addr_p0 [4];
    logic [31:0]       lane_data_p0 [4];

    logic [3:0]        grant;
    logic [3:0]        sel_vld;
    logic [1:0]        sel_lane [4];

    logic [ROW_W-1:0]  bank_addr_p1 [4];
    logic [31:0]       bank_data_p1 [4];
    logic [3:0]        bank_we_p1 [4];
    logic              vld_p1;

    assign vaddr[0] = vreq_addr0;
    assign vaddr[1] = vreq_addr1;
    assign vaddr[2] = vreq_addr2;
    assign vaddr[3] = vreq_addr3;
    assign vdata[0] = vreq_data0;
    assign vdata[1] = vreq_data1;
    assign vdata[2] = vreq_data2;
    assign vdata[3] = vreq_data3;

    // A pending lane is granted unless a lower pending lane targets the same bank,
    // so same-address lanes drain in lane order and the highest lane's data lands last.
    always_comb begin
        grant = pending;
        for (int i = 1; i < 4; i++) begin
            for (int j = 0; j < i; j++) begin
                if (pending[j] && (lane_addr_p0[j][1:0] == lane_addr_p0[i][1:0])) begin
                    grant[i] = 1'b0;
                end
            end
        end
        for (int b = 0; b < 4; b++) begin
            sel_vld[b]  = 1'b0;
            sel_lane[b] = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (grant[i] && (lane_addr_p0[i][1:0] == 2'(b))) begin
                    sel_vld[b]  = 1'b1;
                    sel_lane[b] = 2'(i);
                end
            end
        end
        pending_nxt = pending & ~grant;
    end

    always_comb begin
        state_nxt  = state;
        accept_sca = 1'b0;
        accept_vec = 1'b0;
        vreq_ready = 1'b0;
        sreq_stall = 1'b0;
        case (state)
            IDLE: begin
                if (sreq_valid) begin
                    accept_sca = 1'b1;
                end else begin
                    vreq_ready = !rst;
                    if (vreq_valid) begin
                        accept_vec = 1'b1;
                        state_nxt  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                sreq_stall = sreq_valid;
                if (pending_nxt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept_vec) begin
                pending <= vreq_mask;
            end else if (state == ISSUE) begin
                pending <= pending_nxt;
            end
        end
    end

    // p0: vector request capture
    always_ff @(posedge clk) begin
        if (accept_vec) begin
            for (int i = 0; i < 4; i++) begin
                lane_addr_p0[i] <= vaddr[i];
                lane_data_p0[i] <= vdata[i];
            end
        end
    end

    // p1: registered bank write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                bank_we_p1[b]   <= 4'd0;
                bank_addr_p1[b] <= '0;
                bank_data_p1[b] <= 32'd0;
            end
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= (state == ISSUE) && (pending_nxt == 4'd0);
            for (int b = 0; b < 4; b++) begin
                bank_we_p1[b] <= 4'd0;
            end
            if (accept_sca) begin
                bank_we_p1[sreq_addr[1:0]]   <= sreq_be;
                bank_addr_p1[sreq_addr[1:0]] <= sreq_addr[ADDR_W-1:2];
                bank_data_p1[sreq_addr[1:0]] <= sreq_data;
            end else if (state == ISSUE) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel_vld[b]) begin
                        bank_we_p1[b]   <= 4'hF;
                        bank_addr_p1[b] <= lane_addr_p0[sel_lane[b]][ADDR_W-1:2];
                        bank_data_p1[b] <= lane_data_p0[sel_lane[b]];
                    end
                end
            end
        end
    end

    assign bank_addr0 = bank_addr_p1[0];
    assign bank_addr1 = bank_addr_p1[1];
    assign bank_addr2 = bank_addr_p1[2];
    assign bank_addr3 = bank_addr_p1[3];
    assign bank_data0 = bank_data_p1[0];
    assign bank_data1 = bank_data_p1[1];
    assign bank_data2 = bank_data_p1[2];
    assign bank_data3 = bank_data_p1[3];
    assign bank_we0   = bank_we_p1[0];
    assign bank_we1   = bank_we_p1[1];
    assign bank_we2   = bank_we_p1[2];
    assign bank_we3   = bank_we_p1[3];
    assign vreq_done  = vld_p1;
    assign busy       = (state == ISSUE);

endmodule

// File: tb/tb_dm_bank_scheduler.sv
// Scoreboard bench for dm_bank_scheduler: the driver predicts every bank-write frame from
// per-bank lane lists and pushes it; a negedge monitor pops and compares each presented frame.
`timescale 1ns/1ps

module tb_dm_bank_scheduler;

    localparam int ADDR_W = 10;
    localparam int ROW_W  = ADDR_W - 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              vreq_valid;
    logic              vreq_ready;
    logic [3:0]        vreq_mask;
    logic [ADDR_W-1:0] vreq_addr0, vreq_addr1, vreq_addr2, vreq_addr3;
    logic [31:0]       vreq_data0, vreq_data1, vreq_data2, vreq_data3;
    logic              vreq_done;
    logic              sreq_valid;
    logic [ADDR_W-1:0] sreq_addr;
    logic [31:0]       sreq_data;
    logic [3:0]        sreq_be;
    logic              sreq_stall;
    logic [ROW_W-1:0]  bank_addr0, bank_addr1, bank_addr2, bank_addr3;
    logic [31:0]       bank_data0, bank_data1, bank_data2, bank_data3;
    logic [3:0]        bank_we0, bank_we1, bank_we2, bank_we3;
    logic              busy;

    dm_bank_scheduler #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .vreq_valid(vreq_valid), .vreq_ready(vreq_ready), .vreq_mask(vreq_mask),
        .vreq_addr0(vreq_addr0), .vreq_addr1(vreq_addr1),
        .vreq_addr2(vreq_addr2), .vreq_addr3(vreq_addr3),
        .vreq_data0(vreq_data0), .vreq_data1(vreq_data1),
        .vreq_data2(vreq_data2), .vreq_data3(vreq_data3),
        .vreq_done(vreq_done),
        .sreq_valid(sreq_valid), .sreq_addr(sreq_addr), .sreq_data(sreq_data),
        .sreq_be(sreq_be), .sreq_stall(sreq_stall),
        .bank_addr0(bank_addr0), .bank_addr1(bank_addr1),
        .bank_addr2(bank_addr2), .bank_addr3(bank_addr3),
        .bank_data0(bank_data0), .bank_data1(bank_data1),
        .bank_data2(bank_data2), .bank_data3(bank_data3),
        .bank_we0(bank_we0), .bank_we1(bank_we1), .bank_we2(bank_we2), .bank_we3(bank_we3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]            cyc;
        logic [3:0][3:0]        we;
        logic [3:0][ROW_W-1:0]  row;
        logic [3:0][31:0]       data;
        logic                   done;
    } frame_t;

    frame_t            sb[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                next_idle = 0;
    logic              mon_en = 1'b0;

    logic [ADDR_W-1:0] va [4];
    logic [31:0]       vd [4];
    logic [3:0]        vm;
    logic [ADDR_W-1:0] sa;
    logic [31:0]       sd;
    logic [3:0]        sbe;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each bank drains its lanes lowest-first, one per cycle, starting two
    // cycles after the accept cycle; an empty mask still costs one cycle and a done pulse.
    task automatic model_vec(input int k, output int n);
        int     lst [4][4];
        int     cnt [4];
        int     b;
        frame_t f;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 4; i++) begin
            if (vm[i]) begin
                b = int'(va[i]) % 4;
                lst[b][cnt[b]] = i;
                cnt[b]++;
            end
        end
        n = 1;
        for (int i = 0; i < 4; i++) if (cnt[i] > n) n = cnt[i];
        for (int j = 0; j < n; j++) begin
            f = '0;
            f.cyc = 32'(k + 2 + j);
            for (int bb = 0; bb < 4; bb++) begin
                if (cnt[bb] > j) begin
                    f.we[bb]   = 4'hF;
                    f.row[bb]  = ROW_W'(va[lst[bb][j]] / 4);
                    f.data[bb] = vd[lst[bb][j]];
                end
            end
            f.done = (j == n - 1);
            sb.push_back(f);
        end
    endtask

    task automatic model_sca(input int k);
        frame_t f;
        f = '0;
        f.cyc = 32'(k + 1);
        f.we[int'(sa) % 4]   = sbe;
        f.row[int'(sa) % 4]  = ROW_W'(sa / 4);
        f.data[int'(sa) % 4] = sd;
        sb.push_back(f);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        while (cyc < next_idle) step();
    endtask

    task automatic drive_vec();
        vreq_mask  = vm;
        vreq_addr0 = va[0]; vreq_addr1 = va[1]; vreq_addr2 = va[2]; vreq_addr3 = va[3];
        vreq_data0 = vd[0]; vreq_data1 = vd[1]; vreq_data2 = vd[2]; vreq_data3 = vd[3];
        vreq_valid = 1'b1;
    endtask

    task automatic drive_sca();
        sreq_addr  = sa;
        sreq_data  = sd;
        sreq_be    = sbe;
        sreq_valid = 1'b1;
    endtask

    task automatic send_vec();
        int n;
        wait_idle();
        drive_vec();
        #1;
        chk("vec_ready", 32'(vreq_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        model_vec(cyc, n);
        next_idle = cyc + n + 1;
        step();
        vreq_valid = 1'b0;
    endtask

    task automatic send_sca();
        wait_idle();
        drive_sca();
        #1;
        chk("sca_no_stall", 32'(sreq_stall), 32'd0);
        chk("sca_vready", 32'(vreq_ready), 32'd0);
        model_sca(cyc);
        next_idle = cyc + 1;
        step();
        sreq_valid = 1'b0;
    endtask

    task automatic send_both();
        int n;
        wait_idle();
        drive_sca();
        drive_vec();
        #1;
        chk("both_vready", 32'(vreq_ready), 32'd0);
        chk("both_stall", 32'(sreq_stall), 32'd0);
        model_sca(cyc);
        step();
        sreq_valid = 1'b0;
        #1;
        chk("both_vready_next", 32'(vreq_ready), 32'd1);
        model_vec(cyc, n);
        next_idle = cyc + n + 1;
        step();
        vreq_valid = 1'b0;
    endtask

    task automatic send_stall();
        send_vec();
        drive_sca();
        #1;
        while (cyc < next_idle) begin
            chk("stall_hold", 32'(sreq_stall), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
            step();
        end
        chk("stall_release", 32'(sreq_stall), 32'd0);
        model_sca(cyc);
        next_idle = cyc + 1;
        step();
        sreq_valid = 1'b0;
    endtask

    task automatic mid_reset();
        send_vec();
        step();
        rst = 1'b1;
        while (sb.size() > 0 && int'(sb[$].cyc) > cyc) void'(sb.pop_back());
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(vreq_ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        next_idle = cyc;
    endtask

    task automatic set_lanes(input logic [ADDR_W-1:0] a0, a1, a2, a3, input logic [3:0] m);
        va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
        for (int i = 0; i < 4; i++) vd[i] = $urandom;
        vm = m;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 4; i++) begin
            va[i] = ADDR_W'($urandom_range(0, 47));
            vd[i] = $urandom;
        end
        vm = 4'($urandom_range(0, 15));
    endtask

    task automatic rand_sca();
        sa  = ADDR_W'($urandom_range(0, 1023));
        sd  = $urandom;
        sbe = 4'($urandom_range(1, 15));
    endtask

    logic [3:0]       act_we [4];
    logic [ROW_W-1:0] act_row [4];
    logic [31:0]      act_data [4];
    frame_t           e;

    always @(negedge clk) begin
        if (mon_en) begin
            act_we[0] = bank_we0; act_we[1] = bank_we1; act_we[2] = bank_we2; act_we[3] = bank_we3;
            act_row[0] = bank_addr0; act_row[1] = bank_addr1;
            act_row[2] = bank_addr2; act_row[3] = bank_addr3;
            act_data[0] = bank_data0; act_data[1] = bank_data1;
            act_data[2] = bank_data2; act_data[3] = bank_data3;
            if (vreq_done || (act_we[0] | act_we[1] | act_we[2] | act_we[3]) != 4'd0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: cycle %0d we=%h%h%h%h done=%0b, none expected",
                             cyc, act_we[3], act_we[2], act_we[1], act_we[0], vreq_done);
                end else begin
                    e = sb.pop_front();
                    chk("out_cycle", 32'(cyc), e.cyc);
                    for (int b = 0; b < 4; b++) begin
                        chk($sformatf("bank_we%0d", b), 32'(act_we[b]), 32'(e.we[b]));
                        if (e.we[b] != 4'd0) begin
                            chk($sformatf("bank_addr%0d", b), 32'(act_row[b]), 32'(e.row[b]));
                            chk($sformatf("bank_data%0d", b), act_data[b], e.data[b]);
                        end
                    end
                    chk("vreq_done", 32'(vreq_done), 32'(e.done));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        rand_lanes();
        rand_sca();
        vm = 4'hF;
        drive_vec();
        drive_sca();
        repeat (2) begin
            step();
            chk("rst_vready", 32'(vreq_ready), 32'd0);
            chk("rst_we", 32'({bank_we3, bank_we2, bank_we1, bank_we0}), 32'd0);
            chk("rst_done", 32'(vreq_done), 32'd0);
        end
        rst        = 1'b0;
        vreq_valid = 1'b0;
        sreq_valid = 1'b0;
        mon_en     = 1'b1;
        #1;
        chk("post_rst_vready", 32'(vreq_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        next_idle = cyc;

        set_lanes(10'h10, 10'h11, 10'h12, 10'h13, 4'hF);
        send_vec();
        set_lanes(10'h04, 10'h08, 10'h0C, 10'h00, 4'hF);
        send_vec();
        set_lanes(10'h10, 10'h11, 10'h12, 10'h13, 4'hF);
        sa = 10'h22; sd = $urandom; sbe = 4'b0011;
        send_both();
        set_lanes(10'h04, 10'h08, 10'h0C, 10'h00, 4'hF);
        rand_sca();
        send_stall();
        set_lanes(10'h05, 10'h0D, 10'h09, 10'h01, 4'b0101);
        send_vec();
        set_lanes(10'h05, 10'h06, 10'h07, 10'h08, 4'b0000);
        send_vec();
        set_lanes(10'h27, 10'h27, 10'h27, 10'h27, 4'hF);
        send_vec();
        set_lanes(10'h04, 10'h08, 10'h0C, 10'h00, 4'hF);
        mid_reset();

        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin rand_lanes(); send_vec(); end
                5, 6:          begin rand_sca(); send_sca(); end
                7:             repeat ($urandom_range(1, 3)) step();
                8:             begin rand_lanes(); rand_sca(); send_both(); end
                default:       begin rand_lanes(); rand_sca(); send_stall(); end
            endcase
        end

        w = 0;
        while (sb.size() > 0 && w < 50) begin
            step();
            w++;
        end
        repeat (3) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
